// File: rtl/snn_packet_out_decoder.sv
// Drains the SNN output-packet FIFO, counts spikes per class over one frame,
// then runs a sequential argmax and reports the winning class.

module snn_class_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && (cnt != '1))  cnt <= cnt + 1'b1;
  end
endmodule

module snn_packet_out_decoder #(
  parameter int NUM_CLASSES  = 10,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             frame_end,
  input  logic [7:0]       packet_out,
  input  logic             packet_out_rempty,
  output logic             packet_out_rinc,
  output logic             busy,
  output logic             result_valid,
  output logic [7:0]       result_class,
  output logic [CNT_W-1:0] result_count,
  output logic [7:0]       invalid_count
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [7:0] LAST = 8'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, ARGMAX, DONE} state_t;

  state_t                                state, nxt;
  logic [DW-1:0]                         empty_run;
  logic [7:0]                            idx;
  logic [7:0]                            best_class;
  logic [CNT_W-1:0]                      best_cnt;
  logic [NUM_CLASSES-1:0]                inc;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]                      cur_cnt;
  logic                                  pop, idx_ok, drain_done, take_cur;
  logic [7:0]                            cand_class;
  logic [CNT_W-1:0]                      cand_cnt;

  assign pop        = packet_out_rinc;
  assign idx_ok     = ({1'b0, packet_out} < 9'(NUM_CLASSES));
  assign drain_done = packet_out_rempty && (empty_run == DW'(DRAIN_CYCLES - 1));

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // next state; start overrides everything, including frame_end
  always_comb begin
    nxt = state;
    if (start) nxt = COLLECT;
    else begin
      case (state)
        COLLECT: if (frame_end)   nxt = DRAIN;
        DRAIN:   if (drain_done)  nxt = ARGMAX;
        ARGMAX:  if (idx == LAST) nxt = DONE;
        DONE:                     nxt = IDLE;
        default:                  nxt = state;
      endcase
    end
  end

  // outputs
  always_comb begin
    packet_out_rinc = ((state == COLLECT) || (state == DRAIN)) && !packet_out_rempty;
    result_valid    = (state == DONE);
    busy            = (state != IDLE);
  end

  // a pop coinciding with start belongs to the old frame and is dropped by the clear
  genvar g;
  generate
    for (g = 0; g < NUM_CLASSES; g++) begin : g_cls
      assign inc[g] = pop && (packet_out == 8'(g));
      snn_class_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start),
        .inc     (inc[g]),
        .cnt     (cnt[g])
      );
    end
  endgenerate

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (idx == 8'(i)) cur_cnt = cnt[i];
  end

  // strict greater-than keeps the lowest index on ties
  assign take_cur   = (idx == 8'd0) || (cur_cnt > best_cnt);
  assign cand_class = take_cur ? idx     : best_class;
  assign cand_cnt   = take_cur ? cur_cnt : best_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      empty_run  <= '0;
      idx        <= '0;
      best_class <= '0;
      best_cnt   <= '0;
    end else begin
      if ((state == DRAIN) && packet_out_rempty) empty_run <= empty_run + DW'(1);
      else                                       empty_run <= '0;
      if (state == ARGMAX && !start) begin
        idx        <= idx + 8'd1;
        best_class <= cand_class;
        best_cnt   <= cand_cnt;
      end else begin
        idx <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_class  <= '0;
      result_count  <= '0;
      invalid_count <= '0;
    end else if (start) begin
      result_class  <= '0;
      result_count  <= '0;
      invalid_count <= '0;
    end else begin
      if (state == ARGMAX && idx == LAST) begin
        result_class <= cand_class;
        result_count <= cand_cnt;
      end
      if (pop && !idx_ok && invalid_count != 8'hFF)
        invalid_count <= invalid_count + 8'd1;
    end
  end
endmodule

// File: doc/snn_packet_out_decoder.md
# snn_packet_out_decoder

Consumer at the read end of the SNN output packet FIFO, in the system clock domain. It pops 8-bit output packets (class/neuron index), keeps a saturating spike count per class for one inference frame, and after the frame ends and the FIFO drains it runs a sequential argmax. It then presents the winning class to the SoC side with a one-cycle valid pulse. It sits between the fall-through packet-out FIFO (`rdata`/`rempty`/`rinc`) and the host CSR logic.

## Interface
Parameters:
- NUM_CLASSES, 10, number of counted classes; legal range 2..256
- CNT_W, 16, width of each per-class spike counter
- DRAIN_CYCLES, 4, consecutive empty cycles needed to declare the FIFO drained

Ports:
- clk  in  1  system clock; the block's only clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; clear counters and begin a frame
- frame_end  in  1  pulse; host has issued the last tick of the frame
- packet_out  in  8  FIFO head data; fall-through, so valid whenever packet_out_rempty=0
- packet_out_rempty  in  1  FIFO empty
- packet_out_rinc  out  1  FIFO pop
- busy  out  1  high in every state except IDLE
- result_valid  out  1  one-cycle pulse; result fields are valid
- result_class  out  8  winning class index
- result_count  out  CNT_W  spike count of the winning class
- invalid_count  out  8  saturating count of packets with index >= NUM_CLASSES in the current frame

## Operation
- States: IDLE, COLLECT, DRAIN, ARGMAX, DONE.
- IDLE: packet_out_rinc=0, and the FIFO is left untouched. start -> COLLECT.
- Entering COLLECT clears all counters and invalid_count to 0. start can arrive in any state, including mid-frame or mid-ARGMAX. It always clears the counters and goes to COLLECT; any in-progress result is discarded with no result_valid.
- COLLECT/DRAIN: packet_out_rinc = ~packet_out_rempty, combinationally. On each pop:
  - if packet_out < NUM_CLASSES, cnt[packet_out] increments, saturating at 2^CNT_W-1;
  - otherwise invalid_count increments, saturating at 255.
- COLLECT: frame_end -> DRAIN. Popping continues in the same cycle.
- DRAIN: an empty-run counter increments each cycle with rempty=1 and resets to 0 on any cycle with rempty=0. When it reaches DRAIN_CYCLES -> ARGMAX. This absorbs CDC latency of the async FIFO empty flag.
- ARGMAX: one class per cycle, idx 0..NUM_CLASSES-1. best is initialised to class 0 with its count. A class replaces best only if its count is strictly greater, so ties resolve to the lowest index. After the last index -> DONE.
- DONE: result_valid=1 for exactly one cycle with result_class/result_count from best, then -> IDLE.
- result_class, result_count and invalid_count hold their values until the next start.
- frame_end outside COLLECT is ignored. If start and frame_end arrive in the same cycle, start wins.

## Timing
- Reset (asynchronous assert):
  - state=IDLE, all counters=0, packet_out_rinc=0, busy=0;
  - result_valid=0, result_class=0, result_count=0, invalid_count=0.
- Reset deassertion is synchronised by the integrator.
- Pop: data sampled and counter updated on the same rising edge at which packet_out_rinc=1. Sustained throughput is 1 packet/cycle.
- start at edge N: state is COLLECT from N+1, and the first pop can occur in cycle N+1.
- frame_end at edge N while in COLLECT: state is DRAIN from N+1.
- The FIFO stays empty from DRAIN entry at edge D: ARGMAX is entered at edge D+DRAIN_CYCLES.
- ARGMAX lasts NUM_CLASSES cycles, then DONE for 1 cycle. result_valid rises NUM_CLASSES cycles after ARGMAX entry.
- busy is registered: high from the cycle after start through DONE inclusive.

## Test plan
- Reset check: assert reset_n=0 mid-COLLECT with FIFO non-empty -> all outputs 0 immediately, and no rinc until a new start.
- Basic frame: start; FIFO feeds 3, 3, 7, 3, 7, 0; frame_end; FIFO stays empty -> result_valid pulse with result_class=3, result_count=3, invalid_count=0. Pulse arrives DRAIN_CYCLES+NUM_CLASSES cycles after DRAIN entry.
- Tie and invalid packets: feed 5, 2, 5, 2, 12, 255 (NUM_CLASSES=10) -> result_class=2, result_count=2, invalid_count=2.
- Late packets: packets arrive during DRAIN after 2 empty cycles -> they are counted, the empty-run counter restarts, and ARGMAX begins only after 4 consecutive empty cycles.
- Saturation, with CNT_W=4: 20 packets of class 1 -> result_count=15, result_class=1.
- Restart: start asserted during ARGMAX -> no result_valid; counters cleared; the next frame of 9, 9 yields result_class=9, result_count=2. Also, frame_end while in IDLE is ignored: state stays IDLE and rinc=0.
